round_div_arbiter: RTL and testbench

- Shares one rounding-divide datapath (divide by 2**DIV_LOG2, round half up, saturate on overflow) between NREQ requesters.
- Each requester presents a valid/ready stream of IN_WIDTH-bit operands. A round-robin arbiter picks one request per cycle, and the result is registered into a single output stage.
- The output stage carries the quotient, the requester ID and a saturation flag.
- Sits between the fixed-point accumulators and the shared writeback path. A free-running saturation event counter is exported for debug.

---
 rtl/round_div_arbiter.sv | 114 +++++++++++
 tb/tb_round_div_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/round_div_arbiter.sv
// round_div_arbiter: round-robin shared rounding divider (x / 2**DIV_LOG2,
// round half up, saturate on overflow) feeding one registered output stage.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req_valid[NREQ]      per-requester operand valid
//   req_data             packed operands, requester i at [i*IN_WIDTH +: IN_WIDTH]
//   req_ready[NREQ]      combinational one-hot grant (zero when stage busy)
//   out_valid/out_ready  result handshake
//   out_data             rounded quotient
//   out_id               requester index that produced out_data
//   out_sat              round-up was suppressed by overflow
//   sat_cnt              saturating count of saturated results accepted downstream
module round_div_arbiter #(
  parameter  int unsigned NREQ      = 4,
  parameter  int unsigned DIV_LOG2  = 3,
  parameter  int unsigned OUT_WIDTH = 32,
  parameter  int unsigned CNT_W     = 16,
  localparam int unsigned IN_WIDTH  = OUT_WIDTH + DIV_LOG2,
  localparam int unsigned ID_W      = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*IN_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_sat,
  output logic [CNT_W-1:0]         sat_cnt
);

  logic [ID_W-1:0]      r_ptr;
  logic                 w_stage_free;
  logic                 w_gnt_any;
  logic [ID_W-1:0]      w_gnt_idx;
  logic [ID_W-1:0]      w_idx;
  logic [IN_WIDTH-1:0]  w_d;
  logic [OUT_WIDTH-1:0] w_q;
  logic [OUT_WIDTH:0]   w_t;
  logic [OUT_WIDTH-1:0] w_res;
  logic                 w_sat;
  logic [ID_W-1:0]      w_ptr_nxt;

  // Grants are suppressed during reset so no handshake can be lost.
  assign w_stage_free = resetn && (!out_valid || out_ready);

  // First valid requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    req_ready = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = ID_W'((32'(r_ptr) + k) % NREQ);
      if (!w_gnt_any && req_valid[w_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
    if (w_stage_free && w_gnt_any) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  // Rounding divide of the granted operand; overflow keeps the truncated quotient.
  always_comb begin
    w_d   = req_data[32'(w_gnt_idx) * IN_WIDTH +: IN_WIDTH];
    w_q   = w_d[IN_WIDTH-1:DIV_LOG2];
    w_t   = {1'b0, w_q} + (OUT_WIDTH+1)'(w_d[DIV_LOG2-1]);
    w_sat = w_t[OUT_WIDTH];
    w_res = w_sat ? w_q : w_t[OUT_WIDTH-1:0];
  end

  assign w_ptr_nxt = (w_gnt_idx == ID_W'(NREQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

  // Round-robin pointer moves past the winner only on an actual grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (w_stage_free && w_gnt_any) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Output stage: load on grant, drain on accept, otherwise hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_sat   <= 1'b0;
    end else if (w_stage_free && w_gnt_any) begin
      out_valid <= 1'b1;
      out_data  <= w_res;
      out_id    <= w_gnt_idx;
      out_sat   <= w_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturation event counter, sticks at all ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && out_sat && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_round_div_arbiter.sv
// Directed bench for round_div_arbiter (NREQ=4, DIV_LOG2=3, OUT_WIDTH=32, CNT_W=4).
module tb_round_div_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DL2   = 3;
  localparam int unsigned OW    = 32;
  localparam int unsigned CW    = 4;
  localparam int unsigned IW    = OW + DL2;
  localparam int unsigned IDW   = 2;

  logic                 clk;
  logic                 resetn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [OW-1:0]        out_data;
  logic [IDW-1:0]       out_id;
  logic                 out_sat;
  logic [CW-1:0]        sat_cnt;

  int n_cmp;
  int n_bad;

  round_div_arbiter #(
    .NREQ(NREQ), .DIV_LOG2(DL2), .OUT_WIDTH(OW), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .out_sat(out_sat),
    .sat_cnt(sat_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [IW-1:0] v);
    req_data[i*IW +: IW] = v;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  logic [1:0] rr_exp [0:4];
  logic [1:0] rr2_exp [0:3];

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    resetn    = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    out_ready = 1'b1;

    // Reset state, with requests pending.
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_id",    64'(out_id),    64'd0);
    check("rst_sat",   64'(out_sat),   64'd0);
    check("rst_cnt",   64'(sat_cnt),   64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    @(negedge clk);
    resetn = 1'b1;
    step();

    // Rounding: 0x14 -> 3 (half rounds up), 0x13 -> 2.
    req_valid = 4'b0001;
    set_op(0, 35'h14);
    @(negedge clk);
    check("rnd0_ready", 64'(req_ready), 64'b0001);
    step();
    check("rnd0_valid", 64'(out_valid), 64'd1);
    check("rnd0_data",  64'(out_data),  64'h3);
    check("rnd0_sat",   64'(out_sat),   64'd0);
    set_op(0, 35'h13);
    step();
    check("rnd1_data",  64'(out_data),  64'h2);
    check("rnd1_id",    64'(out_id),    64'd0);

    // Saturation on req2; ptr is 1 here.
    req_valid = 4'b0100;
    set_op(2, {32'hFFFF_FFFF, 3'b100});
    step();
    check("sat_data", 64'(out_data), 64'hFFFF_FFFF);
    check("sat_id",   64'(out_id),   64'd2);
    check("sat_flag", 64'(out_sat),  64'd1);
    check("sat_cnt0", 64'(sat_cnt),  64'd0);
    req_valid = '0;
    step();
    check("sat_cnt1",  64'(sat_cnt),   64'd1);
    check("sat_drain", 64'(out_valid), 64'd0);
    req_valid = 4'b0100;
    set_op(2, {32'hFFFF_FFFF, 3'b011});
    step();
    check("nosat_data", 64'(out_data), 64'hFFFF_FFFF);
    check("nosat_flag", 64'(out_sat),  64'd0);
    req_valid = '0;
    step();
    check("nosat_cnt", 64'(sat_cnt), 64'd1);

    // Round-robin from ptr 0: 0,1,2,3,0; requester i yields i+1.
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 35'((i + 1) * 8));
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd2; rr_exp[3] = 2'd3; rr_exp[4] = 2'd0;
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("rr_ready%0d", c), 64'(req_ready), 64'(4'b0001 << rr_exp[c]));
      step();
      check($sformatf("rr_id%0d", c), 64'(out_id), 64'(rr_exp[c]));
      check($sformatf("rr_data%0d", c), 64'(out_data), 64'(rr_exp[c]) + 64'd1);
    end
    // Drop req1 with ptr at 1: 2,3,0,2.
    req_valid = 4'b1101;
    rr2_exp[0] = 2'd2; rr2_exp[1] = 2'd3; rr2_exp[2] = 2'd0; rr2_exp[3] = 2'd2;
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("rr2_id%0d", c), 64'(out_id), 64'(rr2_exp[c]));
      check($sformatf("rr2_valid%0d", c), 64'(out_valid), 64'd1);
    end

    // Backpressure: pending result id 2 / data 3 must hold for 5 cycles.
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_ready%0d", c), 64'(req_ready), 64'd0);
      step();
      check($sformatf("bp_valid%0d", c), 64'(out_valid), 64'd1);
      check($sformatf("bp_id%0d", c),    64'(out_id),    64'd2);
      check($sformatf("bp_data%0d", c),  64'(out_data),  64'd3);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(req_ready), 64'b1000);
    step();
    check("bp_release_id",   64'(out_id),   64'd3);
    check("bp_release_data", 64'(out_data), 64'd4);

    // Reset mid-stream with ptr=2 and a pending result.
    req_valid = 4'b0010;
    step();
    check("mid_id", 64'(out_id), 64'd1);
    req_valid = '0;
    out_ready = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("mid_async_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    resetn    = 1'b1;
    req_valid = 4'b1001;
    out_ready = 1'b1;
    #1;
    check("mid_ready", 64'(req_ready), 64'b0001);
    step();
    check("mid_post_id",   64'(out_id),   64'd0);
    check("mid_post_data", 64'(out_data), 64'd1);

    // Counter limit: 17 saturated handshakes stick at 15.
    do_reset();
    set_op(0, {32'hFFFF_FFFF, 3'b100});
    req_valid = 4'b0001;
    for (int c = 1; c <= 17; c++) begin
      step();
      if (c == 15) check("cnt_14", 64'(sat_cnt), 64'd14);
      if (c == 16) check("cnt_15", 64'(sat_cnt), 64'd15);
    end
    req_valid = '0;
    step();
    check("cnt_hold", 64'(sat_cnt), 64'd15);
    check("cnt_idle", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
